// File: rtl/fsm_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin resource arbiter.
package fsm_rr_arbiter_pkg;

    // Gray-coded sequencing states: a single bit flips on every legal transition.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_START   = 2'b01,
        ST_BUSY    = 2'b11,
        ST_RELEASE = 2'b10
    } arb_state_e;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int unsigned idw_f(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fsm_rr_arbiter_if.sv
// Requester/resource handshake bundle for the round-robin arbiter.
interface fsm_rr_arbiter_if
    import fsm_rr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) ();

    localparam int unsigned IDW = idw_f(NREQ);

    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            start;
    logic            busy;
    logic            timeout;

    // Requester / resource side: drives requests and completion.
    modport master (
        output req, done,
        input  gnt, gnt_id, start, busy, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, done,
        output gnt, gnt_id, start, busy, timeout
    );

endinterface

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request searching ptr+1, ptr+2, ... mod NREQ.
module fsm_rr_arbiter_rr_pick
    import fsm_rr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            any_o,
    output logic [IDW-1:0]  idx_o
);

    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] shifted;

    // Walk offsets from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        any_o   = 1'b0;
        idx_o   = '0;
        cand    = '0;
        shifted = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand    = IDW'((int'(ptr_i) + k) % int'(NREQ));
            shifted = req_i >> cand;
            if (shifted[0]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter that lends one shared sequencer to NREQ requesters,
// one grant at a time, with a start pulse and a done-or-timeout release.
module fsm_rr_arbiter
    import fsm_rr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    fsm_rr_arbiter_if.slave   bus
);

    localparam int unsigned IDW = idw_f(NREQ);
    localparam int unsigned CW  = $clog2(MAX_HOLD + 1);

    (* syn_encoding = "gray" *) arb_state_e state_q;
    arb_state_e state_d;

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic            pick_any;
    logic [IDW-1:0]  pick_idx;

    fsm_rr_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Next state and next registered outputs; req is only consulted in IDLE.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                if (pick_any) begin
                    state_d  = ST_START;
                    gnt_d    = NREQ'(1) << pick_idx;
                    gnt_id_d = pick_idx;
                    start_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
                hold_d  = '0;
                busy_d  = 1'b1;
            end
            ST_BUSY: begin
                busy_d = 1'b1;
                hold_d = hold_q + CW'(1);
                if (bus.done) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (hold_q == CW'(MAX_HOLD - 1)) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                ptr_d    = gnt_id_q;
                gnt_id_d = '0;
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State, pointer, hold counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= IDW'(NREQ - 1);
            hold_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.start   = start_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed bench for fsm_rr_arbiter: vector table plus hand-written corner sequences.
module tb_fsm_rr_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fsm_rr_arbiter_if #(.NREQ(4)) b ();
    fsm_rr_arbiter_if #(.NREQ(1)) b1 ();

    fsm_rr_arbiter #(.NREQ(4), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    fsm_rr_arbiter #(.NREQ(1), .MAX_HOLD(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       id_dc;
        logic       start;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push(input logic r, input logic [3:0] rq, input logic d,
                                 input logic [3:0] g, input logic [1:0] id, input logic iddc,
                                 input logic s, input logic bz, input logic to);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d; v.gnt = g; v.id = id; v.id_dc = iddc;
        v.start = s; v.busy = bz; v.to = to;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic s,
                             input logic bz, input logic to);
        check({tag, "_gnt"},   32'(b.gnt),     32'(g));
        check({tag, "_start"}, 32'(b.start),   32'(s));
        check({tag, "_busy"},  32'(b.busy),    32'(bz));
        check({tag, "_to"},    32'(b.timeout), 32'(to));
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int last_start;
        int n_starts;
        logic released;

        reset   = 1'b1;
        b.req   = 4'b1111;
        b.done  = 1'b0;
        b1.req  = 1'b0;
        b1.done = 1'b0;

        // Reset, first grant with done three BUSY cycles later, then fair rotation.
        push(1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        push(1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        push(0, 4'b1111, 0, 4'b0001, 0, 0, 1, 1, 0);
        push(0, 4'b1111, 0, 4'b0001, 0, 0, 0, 1, 0);
        push(0, 4'b1111, 0, 4'b0001, 0, 0, 0, 1, 0);
        push(0, 4'b1111, 0, 4'b0001, 0, 0, 0, 1, 0);
        push(0, 4'b1111, 1, 4'b0000, 0, 1, 0, 0, 0);
        push(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            logic [3:0] oh;
            logic [1:0] id;
            id = 2'(k % 4);
            oh = 4'b0001 << id;
            push(0, 4'b1111, 0, oh, id, 0, 1, 1, 0);
            push(0, 4'b1111, 0, oh, id, 0, 0, 1, 0);
            push(0, 4'b1111, 0, oh, id, 0, 0, 1, 0);
            push(0, 4'b1111, 1, 4'b0000, 0, 1, 0, 0, 0);
            push(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        end
        push(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
        push(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            reset  = vq[i].rst;
            b.req  = vq[i].req;
            b.done = vq[i].done;
            step();
            check_out(tag, vq[i].gnt, vq[i].start, vq[i].busy, vq[i].to);
            if (!vq[i].id_dc)
                check({tag, "_id"}, 32'(b.gnt_id), 32'(vq[i].id));
        end

        // Timeout: lone request, done never comes; START plus 8 BUSY cycles.
        b.req = 4'b0100;
        step();
        check_out("to_start", 4'b0100, 1, 1, 0);
        check("to_start_id", 32'(b.gnt_id), 32'd2);
        busy_cycles = 1;
        released = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (b.busy) begin
                busy_cycles++;
                check("to_early", 32'(b.timeout), 32'd0);
            end else begin
                released = 1'b1;
                break;
            end
        end
        check("to_released", 32'(released), 32'd1);
        check("to_busy_cycles", 32'(busy_cycles), 32'd9);
        check_out("to_release", 4'b0000, 0, 0, 1);
        b.req = 4'b0000;
        step();
        check_out("to_after", 4'b0000, 0, 0, 0);

        // done ignored in START; done coinciding with the hold limit wins, no timeout.
        b.req = 4'b0100;
        step();
        check_out("lim_start", 4'b0100, 1, 1, 0);
        b.done = 1'b1;
        step();
        check_out("lim_done_in_start", 4'b0100, 0, 1, 0);
        b.done = 1'b0;
        for (int n = 0; n < 7; n++) begin
            step();
            check_out($sformatf("lim_busy%0d", n), 4'b0100, 0, 1, 0);
        end
        b.done = 1'b1;
        step();
        check_out("lim_release", 4'b0000, 0, 0, 0);
        b.done = 1'b0;
        b.req  = 4'b0000;
        step();
        check_out("lim_after", 4'b0000, 0, 0, 0);

        // Requester drops (and goes unknown) mid-grant; others wait their turn.
        b.req = 4'b0100;
        step();
        check_out("drop_start", 4'b0100, 1, 1, 0);
        step();
        b.req = 4'bxxxx;
        step();
        check_out("drop_x", 4'b0100, 0, 1, 0);
        b.req = 4'b0000;
        step();
        check_out("drop_zero", 4'b0100, 0, 1, 0);
        b.req = 4'b1111;
        step();
        check_out("drop_newreq", 4'b0100, 0, 1, 0);
        b.done = 1'b1;
        step();
        check_out("drop_release", 4'b0000, 0, 0, 0);
        b.done = 1'b0;
        step();
        check_out("drop_idle", 4'b0000, 0, 0, 0);
        step();
        check_out("next_start", 4'b1000, 1, 1, 0);
        check("next_id", 32'(b.gnt_id), 32'd3);

        // Reset while BUSY with requester 3 granted; pointer returns to favour 0.
        step();
        check_out("rst_busy", 4'b1000, 0, 1, 0);
        reset = 1'b1;
        step();
        check_out("rst_clear", 4'b0000, 0, 0, 0);
        check("rst_id", 32'(b.gnt_id), 32'd0);
        reset = 1'b0;
        step();
        check_out("rst_regrant", 4'b0001, 1, 1, 0);
        check("rst_regrant_id", 32'(b.gnt_id), 32'd0);
        b.req = 4'b0000;
        step();
        b.done = 1'b1;
        step();
        b.done = 1'b0;
        step();
        check_out("rst_tail", 4'b0000, 0, 0, 0);

        // Single-requester build: full sequence, start every 4 cycles with immediate done.
        b1.req = 1'b1;
        last_start = -1;
        n_starts = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            b1.done = b1.busy & ~b1.start;
            step();
            if (b1.start) begin
                check("n1_gnt", 32'(b1.gnt), 32'd1);
                check("n1_id", 32'(b1.gnt_id), 32'd0);
                if (last_start >= 0)
                    check("n1_gap", 32'(cyc - last_start), 32'd4);
                last_start = cyc;
                n_starts++;
            end
        end
        check("n1_starts", 32'(n_starts >= 9), 32'd1);
        b1.req  = 1'b0;
        b1.done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
